// File: rtl/debug_collector.sv
// debug_collector
//   Waits for the core to halt, forces it into debug mode and sweeps its
//   architectural state (PC, 32 registers, MEM_WORDS data-memory words).
//   Each 32-bit word is sent MSB byte first to a byte transmitter through a
//   tx_start / tx_done handshake.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   halt_flag       : core halted; a sweep starts on a fresh (re-armed) halt
//   in_pc           : core PC
//   in_reg_data     : register file read data for out_addr_debug
//   in_mem_data     : data memory read data for out_addr_debug
//   tx_done         : transmitter finished the current byte (1-cycle pulse)
//   debug_flag      : forces the core into debug mode during the sweep
//   out_addr_debug  : register index / memory word address to the core
//   out_byte        : byte to transmit
//   tx_start        : 1-cycle request to send out_byte
//   busy            : sweep in progress (mirrors debug_flag)
//   done            : 1-cycle pulse after the last byte is acknowledged
module debug_collector #(
  parameter int LEN       = 32,
  parameter int NB        = $clog2(LEN),
  parameter int MEM_WORDS = 16,
  parameter int READ_LAT  = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           halt_flag,
  input  logic [LEN-1:0] in_pc,
  input  logic [LEN-1:0] in_reg_data,
  input  logic [LEN-1:0] in_mem_data,
  input  logic           tx_done,
  output logic           debug_flag,
  output logic [LEN-1:0] out_addr_debug,
  output logic [7:0]     out_byte,
  output logic           tx_start,
  output logic           busy,
  output logic           done
);

  localparam int BPW = LEN / 8;
  localparam int BW  = $clog2(BPW) + 1;
  localparam int MW  = $clog2(MEM_WORDS) + 1;
  localparam int WW  = $clog2(READ_LAT) + 1;

  typedef enum logic [2:0] {IDLE, SET_ADDR, LATCH, SEND, WAIT_TX, DONE} state_t;
  typedef enum logic [1:0] {PH_PC, PH_REG, PH_MEM} phase_t;

  state_t         state;
  phase_t         phase;
  logic           armed;
  logic [NB-1:0]  reg_idx;
  logic [MW-1:0]  mem_idx;
  logic [WW-1:0]  wait_cnt;
  logic [BW-1:0]  byte_cnt;
  logic [LEN-1:0] shift;
  logic [LEN-1:0] shift_nxt;
  logic [LEN-1:0] src;

  assign shift_nxt = shift << 4'd8;

  // Select the read-data source for the word currently being dumped.
  always_comb begin
    src = in_mem_data;
    case (phase)
      PH_PC:   src = in_pc;
      PH_REG:  src = in_reg_data;
      PH_MEM:  src = in_mem_data;
      default: src = in_mem_data;
    endcase
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      phase          <= PH_PC;
      armed          <= 1'b1;
      reg_idx        <= '0;
      mem_idx        <= '0;
      wait_cnt       <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
      debug_flag     <= 1'b0;
      out_addr_debug <= '0;
      out_byte       <= 8'h00;
      tx_start       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt_flag) begin
            armed <= 1'b1;
          end else if (armed) begin
            state          <= SET_ADDR;
            phase          <= PH_PC;
            reg_idx        <= '0;
            mem_idx        <= '0;
            wait_cnt       <= '0;
            out_addr_debug <= '0;
            debug_flag     <= 1'b1;
            busy           <= 1'b1;
          end
        end
        SET_ADDR: begin
          // Address has been on the bus since entry; give the core READ_LAT cycles.
          if (wait_cnt == WW'(READ_LAT - 1)) begin
            state <= LATCH;
          end else begin
            wait_cnt <= wait_cnt + WW'(32'd1);
          end
        end
        LATCH: begin
          // First byte and tx_start are registered here so they appear during SEND.
          shift    <= src;
          out_byte <= src[LEN-1 -: 8];
          byte_cnt <= '0;
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            shift    <= shift_nxt;
            byte_cnt <= byte_cnt + BW'(32'd1);
            if (byte_cnt != BW'(BPW - 1)) begin
              out_byte <= shift_nxt[LEN-1 -: 8];
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              wait_cnt <= '0;
              state    <= SET_ADDR;
              case (phase)
                PH_PC: begin
                  phase          <= PH_REG;
                  reg_idx        <= '0;
                  out_addr_debug <= '0;
                end
                PH_REG: begin
                  if (reg_idx == NB'(32'd31)) begin
                    phase          <= PH_MEM;
                    mem_idx        <= '0;
                    out_addr_debug <= '0;
                  end else begin
                    reg_idx        <= reg_idx + NB'(32'd1);
                    out_addr_debug <= LEN'(reg_idx) + LEN'(32'd1);
                  end
                end
                default: begin
                  if (mem_idx == MW'(MEM_WORDS - 1)) begin
                    state          <= DONE;
                    done           <= 1'b1;
                    debug_flag     <= 1'b0;
                    busy           <= 1'b0;
                    armed          <= 1'b0;
                    out_addr_debug <= '0;
                  end else begin
                    mem_idx        <= mem_idx + MW'(32'd1);
                    out_addr_debug <= LEN'(mem_idx) + LEN'(32'd1);
                  end
                end
              endcase
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/debug_collector.md
Name: debug_collector

Overview:
- Debug-side counterpart of the MIPS core's debug port.
- Waits for the core's halt_flag, then takes the core into debug mode and sweeps the architectural state: PC, register file, then data memory. It drives the debug address and reads back the core's debug outputs.
- Serializes every 32-bit word, MSB byte first, to a byte transmitter (UART TX) with a start/done handshake.
- Sits between top_mips and the UART transmitter in the board-level top.

Parameters:
- LEN, 32, datapath word width (multiple of 8).
- NB, $clog2(LEN), register index width.
- MEM_WORDS, 16, number of data-memory words dumped (addresses 0..MEM_WORDS-1).
- READ_LAT, 1, cycles between driving the debug address and sampling read data (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- halt_flag  input  1  core halted (from top_mips halt_flag).
- in_pc  input  LEN  core PC (from out_pc).
- in_reg_data  input  LEN  register read data (from out_reg1_recolector).
- in_mem_data  input  LEN  data memory read data (from out_mem_wire).
- tx_done  input  1  transmitter finished current byte (1-cycle pulse).
- debug_flag  output  1  forces the core into debug mode.
- out_addr_debug  output  LEN  register index or memory word address driven to the core.
- out_byte  output  8  byte to transmit.
- tx_start  output  1  1-cycle request to send out_byte.
- busy  output  1  sweep in progress.
- done  output  1  1-cycle pulse when the last byte has been acknowledged.

Behaviour:
- Clock and reset: single clock, all state on posedge clk. Reset is synchronous and active-high.
- Reset values: all outputs 0. FSM goes to IDLE. armed=1; all counters 0.
- FSM states: IDLE, SET_ADDR, LATCH, SEND, WAIT_TX, DONE.
- IDLE:
  - If halt_flag=1 and armed=1: go to SET_ADDR with phase=PC, word index 0, and set debug_flag=1 and busy=1.
  - If halt_flag=0: set armed=1.
- SET_ADDR:
  - Drive out_addr_debug: 0 for PC; the register index for REG; the memory index for MEM. Upper bits are zero.
  - Hold for READ_LAT cycles (wait counter), then go to LATCH.
- LATCH: load a LEN-bit shift register from the phase source (in_pc / in_reg_data / in_mem_data). byte_cnt=0. Go to SEND.
- SEND:
  - out_byte = shift[LEN-1:LEN-8].
  - tx_start=1 for exactly this cycle. Go to WAIT_TX.
- WAIT_TX:
  - out_byte stays stable.
  - On tx_done: shift left by 8 and increment byte_cnt.
    - If more bytes remain in the word: go to SEND.
    - Otherwise advance the word: PC goes to REG index 0; REG index 31 goes to MEM index 0; MEM index MEM_WORDS-1 goes to DONE; any other index increments and goes to SET_ADDR.
  - tx_done in any other state is ignored.
- DONE:
  - done=1 for one cycle, with debug_flag=0, busy=0 and armed=0.
  - Return to IDLE. No new sweep starts until halt_flag has dropped and risen again.
- Byte count and latency:
  - Total bytes = (LEN/8)*(1+32+MEM_WORDS). Default is 196.
  - The first tx_start occurs READ_LAT+2 cycles after the triggering halt_flag sample.
- Signal levels during the sweep:
  - debug_flag stays high continuously from leaving IDLE until DONE.
  - busy equals debug_flag.
  - out_addr_debug holds its value throughout SET_ADDR..WAIT_TX of each word.
- halt_flag deasserting mid-sweep: ignored, and the sweep completes.
- Reset asserted mid-sweep: next cycle is IDLE with all outputs 0 and armed=1. Any partial transfer is abandoned.
- tx_done in the same cycle as tx_start: not possible by protocol (the transmitter responds later). If it occurs, it is ignored because the FSM is in SEND.

Test Plan:
- Reset: hold reset 3 cycles with halt_flag=1 -> all outputs 0; after release the sweep starts, with debug_flag=1 on the following cycle.
- Full dump, MEM_WORDS=4, model core returning pc=0x00000040, reg[i]=i*0x01010101 and mem[i]=0xA0000000+i, transmitter acknowledging 3 cycles after each tx_start:
  - exactly 148 tx_start pulses;
  - bytes 00 00 00 40, then 00 00 00 00, 01 01 01 01, ...;
  - final bytes A0 00 00 03;
  - done pulses once; debug_flag then returns to 0.
- Address sequence: check out_addr_debug = 0 (PC), then 0..31, then 0..3, each held until its 4th tx_done; READ_LAT=2 gives 2 wait cycles per word.
- Re-arm: keep halt_flag=1 after done -> no second sweep; drop halt_flag 1 cycle, then raise it -> a second identical 148-byte sweep.
- Mid-sweep reset: assert reset during register index 10 -> next cycle tx_start=0, debug_flag=0, busy=0; a new sweep starts from PC after release.
- Stray tx_done: pulse tx_done in IDLE and in SEND -> no shift, no byte_cnt change, and the byte stream is unchanged.
